// File: rtl/traffic_pkg.sv
// Shared light encodings, fault codes and width defaults for the traffic light monitor.
package traffic_pkg;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  localparam int unsigned MIN_GREEN_DEF = 4;
  localparam int unsigned MAX_PHASE_DEF = 64;
  localparam int unsigned EMERG_LAT_DEF = 8;
  localparam int unsigned CNT_W_DEF     = 8;

  typedef enum logic [2:0] {
    FcNone       = 3'd0,
    FcIllegal    = 3'd1,
    FcConflict   = 3'd2,
    FcBadSeq     = 3'd3,
    FcShortGreen = 3'd4,
    FcWatchdog   = 3'd5,
    FcEmergMiss  = 3'd6
  } fault_code_e;

  function automatic logic is_light(input logic [2:0] code);
    return (code == LT_RED) || (code == LT_YEL) || (code == LT_GRN);
  endfunction

  // Lowest code wins when several checks fail on the same sample.
  function automatic fault_code_e pick_code(input logic [6:1] flags);
    if (flags[1]) return FcIllegal;
    if (flags[2]) return FcConflict;
    if (flags[3]) return FcBadSeq;
    if (flags[4]) return FcShortGreen;
    if (flags[5]) return FcWatchdog;
    if (flags[6]) return FcEmergMiss;
    return FcNone;
  endfunction

endpackage

// File: rtl/tl_road_tracker.sv
// Per-road history: last legal light, phase length counter, and the sequence/timing flags
// derived from them for the current sample.
module tl_road_tracker
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN = MIN_GREEN_DEF,
  parameter int unsigned MAX_PHASE = MAX_PHASE_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light,
  input  logic       emergency,
  input  logic       legal,
  output logic       bad_seq,
  output logic       short_green,
  output logic       watchdog
);

  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [CNT_W-1:0] MinGreen = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MaxPhase = CNT_W'(MAX_PHASE);

  logic [2:0]       prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             changed;
  logic             seq_ok;

  always_comb begin
    changed = (light != prev_q);
    if (changed) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q == CntMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    seq_ok = !changed
           || (prev_q == LT_GRN && light == LT_YEL)
           || (prev_q == LT_YEL && light == LT_RED)
           || (prev_q == LT_RED && light == LT_GRN)
           || (prev_q == LT_GRN && light == LT_RED && emergency);

    bad_seq     = legal && !seq_ok;
    short_green = legal && !emergency && (prev_q == LT_GRN) && (light == LT_YEL)
                && (cnt_q < MinGreen);
    // Equality only, so a light stuck past the limit reports once.
    watchdog    = legal && !emergency && (cnt_d == MaxPhase);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= LT_RED;
      cnt_q  <= '0;
    end else if (legal) begin
      prev_q <= light;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive safety checker on the signal heads: samples both roads and emergency, raises a
// prioritised one-cycle fault pulse, a sticky first-fault record and an emergency counter.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN = MIN_GREEN_DEF,
  parameter int unsigned MAX_PHASE = MAX_PHASE_DEF,
  parameter int unsigned EMERG_LAT = EMERG_LAT_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       main_rd,
  input  logic [2:0]       side_rd,
  input  logic             emergency,
  input  logic             clr_fault,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             fault_sticky,
  output logic [2:0]       sticky_code,
  output logic [CNT_W-1:0] emerg_events
);

  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [CNT_W-1:0] EmergLat = CNT_W'(EMERG_LAT);

  // Input sample stage; valid_q keeps the reset-valued sample out of the checks.
  logic             valid_q;
  logic [2:0]       main_q;
  logic [2:0]       side_q;
  logic             emerg_q;
  logic             emerg_prev_q;
  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] timer_d;

  logic             legal;
  logic             both_red;
  logic             emerg_rise;
  logic [6:1]       flags;
  logic             fault_d;
  fault_code_e      code_d;

  logic main_bad_seq, main_short, main_wdog;
  logic side_bad_seq, side_short, side_wdog;

  tl_road_tracker #(
    .MIN_GREEN (MIN_GREEN),
    .MAX_PHASE (MAX_PHASE),
    .CNT_W     (CNT_W)
  ) u_main (
    .clk         (clk),
    .rst         (rst),
    .light       (main_q),
    .emergency   (emerg_q),
    .legal       (legal),
    .bad_seq     (main_bad_seq),
    .short_green (main_short),
    .watchdog    (main_wdog)
  );

  tl_road_tracker #(
    .MIN_GREEN (MIN_GREEN),
    .MAX_PHASE (MAX_PHASE),
    .CNT_W     (CNT_W)
  ) u_side (
    .clk         (clk),
    .rst         (rst),
    .light       (side_q),
    .emergency   (emerg_q),
    .legal       (legal),
    .bad_seq     (side_bad_seq),
    .short_green (side_short),
    .watchdog    (side_wdog)
  );

  always_comb begin
    legal      = valid_q && is_light(main_q) && is_light(side_q);
    both_red   = (main_q == LT_RED) && (side_q == LT_RED);
    emerg_rise = valid_q && emerg_q && !emerg_prev_q;

    if (!valid_q || !emerg_q || both_red) begin
      timer_d = '0;
    end else if (timer_q == CntMax) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    flags[1] = valid_q && !(is_light(main_q) && is_light(side_q));
    flags[2] = valid_q && (main_q != LT_RED) && (side_q != LT_RED);
    flags[3] = main_bad_seq || side_bad_seq;
    flags[4] = main_short || side_short;
    flags[5] = main_wdog || side_wdog;
    flags[6] = (timer_d == EmergLat) && (timer_q != EmergLat);

    fault_d = |flags;
    code_d  = pick_code(flags);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      main_q       <= LT_RED;
      side_q       <= LT_RED;
      emerg_q      <= 1'b0;
      emerg_prev_q <= 1'b0;
      timer_q      <= '0;
      fault        <= 1'b0;
      fault_code   <= 3'd0;
      fault_sticky <= 1'b0;
      sticky_code  <= 3'd0;
      emerg_events <= '0;
    end else begin
      valid_q      <= 1'b1;
      main_q       <= main_rd;
      side_q       <= side_rd;
      emerg_q      <= emergency;
      emerg_prev_q <= emerg_q;
      timer_q      <= timer_d;
      fault        <= fault_d;
      fault_code   <= code_d;
      if (emerg_rise && (emerg_events != CntMax)) begin
        emerg_events <= emerg_events + 1'b1;
      end
      // Clear beats a coincident fault; the pulse itself is still emitted.
      if (clr_fault) begin
        fault_sticky <= 1'b0;
        sticky_code  <= 3'd0;
      end else if (fault_d && !fault_sticky) begin
        fault_sticky <= 1'b1;
        sticky_code  <= code_d;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: one task per scenario, hand-computed expectations.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] main_rd = R;
  logic [2:0] side_rd = R;
  logic       emergency = 1'b0;
  logic       clr_fault = 1'b0;
  logic       fault;
  logic [2:0] fault_code;
  logic       fault_sticky;
  logic [2:0] sticky_code;
  logic [7:0] emerg_events;

  int checks = 0;
  int errors = 0;
  int nfaults = 0;
  logic [2:0] last_code = 3'd0;

  traffic_light_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .main_rd      (main_rd),
    .side_rd      (side_rd),
    .emergency    (emergency),
    .clr_fault    (clr_fault),
    .fault        (fault),
    .fault_code   (fault_code),
    .fault_sticky (fault_sticky),
    .sticky_code  (sticky_code),
    .emerg_events (emerg_events)
  );

  always #5 clk = ~clk;

  // Drive one sample; on return the outputs describe the previously applied sample.
  task automatic apply(input logic [2:0] m, input logic [2:0] s, input logic e);
    main_rd = m;
    side_rd = s;
    emergency = e;
    @(negedge clk);
    if (fault === 1'b1) begin
      nfaults++;
      last_code = fault_code;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    main_rd = R;
    side_rd = R;
    emergency = 1'b0;
    clr_fault = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nfaults = 0;
    last_code = 3'd0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({fault, fault_code, fault_sticky, sticky_code, emerg_events} !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {fault, fault_code, fault_sticky, sticky_code, emerg_events});
    end
  endtask

  task automatic test_legal_cycle();
    do_reset();
    repeat (10) apply(G, R, 1'b0);
    repeat (3)  apply(Y, R, 1'b0);
    apply(R, R, 1'b0);
    repeat (10) apply(R, G, 1'b0);
    repeat (3)  apply(R, Y, 1'b0);
    repeat (2)  apply(R, R, 1'b0);
    repeat (4)  apply(G, R, 1'b0);
    apply(G, R, 1'b0);
    checks++;
    if (nfaults !== 0) begin
      errors++;
      $display("FAIL legal_cycle_faults got %0d want 0", nfaults);
    end
    checks++;
    if (fault_sticky !== 1'b0) begin
      errors++;
      $display("FAIL legal_cycle_sticky got %0d want 0", fault_sticky);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    repeat (5) apply(G, R, 1'b0);
    apply(G, Y, 1'b0);
    apply(G, R, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd2) begin
      errors++;
      $display("FAIL conflict_pulse got %0d/%0d want 1/2", fault, fault_code);
    end
    apply(G, R, 1'b0);
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL conflict_one_cycle got %0d want 0", fault);
    end
    checks++;
    if (fault_sticky !== 1'b1 || sticky_code !== 3'd2) begin
      errors++;
      $display("FAIL conflict_sticky got %0d/%0d want 1/2", fault_sticky, sticky_code);
    end
  endtask

  task automatic test_illegal_code();
    do_reset();
    repeat (5) apply(G, R, 1'b0);
    apply(3'b011, R, 1'b0);
    apply(Y, R, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd1) begin
      errors++;
      $display("FAIL illegal_pulse got %0d/%0d want 1/1", fault, fault_code);
    end
    apply(Y, R, 1'b0);
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL illegal_prev_held got code %0d want no fault", fault_code);
    end
  endtask

  task automatic test_short_green();
    do_reset();
    repeat (2) apply(G, R, 1'b0);
    apply(Y, R, 1'b0);
    apply(Y, R, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd4) begin
      errors++;
      $display("FAIL short_green got %0d/%0d want 1/4", fault, fault_code);
    end
    // Exactly MIN_GREEN is long enough.
    do_reset();
    repeat (4) apply(G, R, 1'b0);
    apply(Y, R, 1'b0);
    apply(Y, R, 1'b0);
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL green_at_min got code %0d want no fault", fault_code);
    end
    do_reset();
    repeat (5) apply(G, R, 1'b0);
    apply(R, R, 1'b0);
    apply(R, R, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd3) begin
      errors++;
      $display("FAIL green_red_no_emerg got %0d/%0d want 1/3", fault, fault_code);
    end
    do_reset();
    repeat (2) apply(G, R, 1'b1);
    repeat (2) apply(R, R, 1'b1);
    apply(R, R, 1'b0);
    apply(R, R, 1'b0);
    checks++;
    if (nfaults !== 0) begin
      errors++;
      $display("FAIL green_red_emerg faults got %0d want 0", nfaults);
    end
  endtask

  task automatic test_emerg_miss();
    do_reset();
    repeat (8) apply(G, R, 1'b1);
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL emerg_before_lat got code %0d want no fault", fault_code);
    end
    apply(G, R, 1'b1);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd6) begin
      errors++;
      $display("FAIL emerg_miss got %0d/%0d want 1/6", fault, fault_code);
    end
    repeat (4) apply(G, R, 1'b1);
    apply(R, R, 1'b1);
    apply(R, R, 1'b1);
    checks++;
    if (nfaults !== 1 || last_code !== 3'd6) begin
      errors++;
      $display("FAIL emerg_single got %0d faults last %0d want 1/6", nfaults, last_code);
    end
    checks++;
    if (emerg_events !== 8'd1) begin
      errors++;
      $display("FAIL emerg_events got %0d want 1", emerg_events);
    end
  endtask

  task automatic test_watchdog_reset();
    do_reset();
    repeat (64) apply(R, R, 1'b0);
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_early got code %0d want no fault", fault_code);
    end
    apply(R, R, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd5) begin
      errors++;
      $display("FAIL watchdog got %0d/%0d want 1/5", fault, fault_code);
    end
    repeat (6) apply(R, R, 1'b0);
    checks++;
    if (nfaults !== 1) begin
      errors++;
      $display("FAIL watchdog_once got %0d want 1", nfaults);
    end
    clr_fault = 1'b1;
    apply(R, R, 1'b0);
    clr_fault = 1'b0;
    checks++;
    if (fault_sticky !== 1'b0 || sticky_code !== 3'd0) begin
      errors++;
      $display("FAIL clear_sticky got %0d/%0d want 0/0", fault_sticky, sticky_code);
    end
    apply(3'b000, R, 1'b1);
    apply(R, R, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd1 || emerg_events !== 8'd1) begin
      errors++;
      $display("FAIL pre_reset got %0d/%0d/%0d want 1/1/1", fault, fault_code, emerg_events);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({fault, fault_code, fault_sticky, sticky_code, emerg_events} !== 16'd0) begin
      errors++;
      $display("FAIL async_reset got %h want 0",
               {fault, fault_code, fault_sticky, sticky_code, emerg_events});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    apply(3'b000, R, 1'b0);
    clr_fault = 1'b1;
    apply(R, R, 1'b0);
    clr_fault = 1'b0;
    checks++;
    if (fault !== 1'b1 || fault_sticky !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins got pulse %0d sticky %0d want 1/0", fault, fault_sticky);
    end
    apply(R, R, 1'b0);
    checks++;
    if (fault_sticky !== 1'b0) begin
      errors++;
      $display("FAIL no_reload got %0d want 0", fault_sticky);
    end
    apply(3'b000, R, 1'b0);
    apply(G, G, 1'b0);
    apply(R, R, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd2) begin
      errors++;
      $display("FAIL second_fault got %0d/%0d want 1/2", fault, fault_code);
    end
    checks++;
    if (fault_sticky !== 1'b1 || sticky_code !== 3'd1) begin
      errors++;
      $display("FAIL sticky_first got %0d/%0d want 1/1", fault_sticky, sticky_code);
    end
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_conflict();
    test_illegal_code();
    test_short_green();
    test_emerg_miss();
    test_watchdog_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
